// File: rtl/fifo_drain_tx.sv
// Drains bytes from an upstream FIFO and serializes each one as a UART-style frame:
// a start bit, then DATA_W data bits LSB first, then a stop bit.
module fifo_drain_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              tx_out,
    output logic              busy,
    output logic              byte_done,
    output logic [7:0]        byte_count
);

    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]       CYC_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [7:0]         cyc_cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shift_reg;
    logic               cyc_last;

    assign cyc_last = (cyc_cnt == CYC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // enable and fifo_empty only matter in IDLE; once a byte is popped the frame always completes
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (cyc_last) next_state = DATA;
            DATA:    if (cyc_last && (bit_idx == BIT_LAST)) next_state = STOP;
            STOP:    if (cyc_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_out    = 1'b1;
        busy      = (state != IDLE);
        byte_done = 1'b0;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = shift_reg[0];
            STOP:    byte_done = cyc_last;
            default: tx_out = 1'b1;
        endcase
    end

    // fifo_rd is registered from next_state so it is high exactly while the FSM sits in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_rd    <= 1'b0;
            shift_reg  <= '0;
            cyc_cnt    <= '0;
            bit_idx    <= '0;
            byte_count <= '0;
        end else begin
            fifo_rd <= (next_state == FETCH);

            if (state == LOAD) begin
                shift_reg <= fifo_data;
            end else if (state == DATA && cyc_last) begin
                shift_reg <= shift_reg >> 1;
            end

            if (state inside {START, DATA, STOP}) begin
                cyc_cnt <= cyc_last ? 8'd0 : cyc_cnt + 8'd1;
            end else begin
                cyc_cnt <= 8'd0;
            end

            if (state == DATA) begin
                if (cyc_last) begin
                    bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_W'(1);
                end
            end else begin
                bit_idx <= '0;
            end

            if (byte_done) begin
                byte_count <= byte_count + 8'd1;
            end
        end
    end

endmodule
